// File: rtl/pcircuit_sample_controller.sv
// Sequences a p-circuit run (clear histogram, burn-in, sample) and histograms sampled patterns.
// Latency: readout 1 cycle; bin increments land 2 cycles after the registered sweep event.
// No backpressure: events may arrive every cycle; start is dropped unless idle.
module pcircuit_sample_controller #(
    parameter int NUM_PBITS = 8,
    parameter int COUNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [7:0]           cfg_clamp,
    input  logic                 cfg_clamp_en,
    input  logic [15:0]          cfg_burn_in,
    input  logic [15:0]          cfg_num_samples,
    output logic                 pc_reset_n,
    output logic [7:0]           clamp,
    output logic                 clamp_EN,
    input  logic [NUM_PBITS-1:0] pc_out,
    input  logic [1:0]           clk_delay,
    output logic                 busy,
    output logic                 done,
    input  logic                 rd_en,
    input  logic [NUM_PBITS-1:0] rd_addr,
    output logic [COUNT_W-1:0]   rd_data,
    output logic                 rd_valid
);

    localparam int DEPTH = 2**NUM_PBITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_BURN,
        ST_SAMPLE
    } state_t;

    state_t state, state_nxt;

    logic [15:0]          burn_in_q, num_samples_q;
    logic [15:0]          burn_cnt, sample_cnt;
    logic [NUM_PBITS-1:0] clr_addr;
    logic [NUM_PBITS-1:0] pc_out_q;
    logic [1:0]           clk_delay_q, clk_delay_prev;
    logic                 primed;
    logic                 evt, burn_evt, hist_evt;
    logic                 start_ok, clr_last, sample_fin;
    logic                 s1_vld;
    logic [NUM_PBITS-1:0] s1_addr;
    logic [COUNT_W-1:0]   s1_cnt, s1_inc;
    logic [COUNT_W-1:0]   mem [DEPTH];

    assign start_ok   = (state == ST_IDLE) && start && !abort;
    assign clr_last   = &clr_addr;
    // First cycle of BURN/SAMPLE only loads the previous-phase register.
    assign evt        = primed && (clk_delay_q != clk_delay_prev);
    assign burn_evt   = evt && (state == ST_BURN);
    assign hist_evt   = evt && (state == ST_SAMPLE) && (sample_cnt != num_samples_q);
    assign sample_fin = (state == ST_SAMPLE) && (sample_cnt == num_samples_q) && !s1_vld;
    assign s1_inc     = (&s1_cnt) ? s1_cnt : s1_cnt + COUNT_W'(1);

    assign pc_reset_n = (state == ST_BURN) || (state == ST_SAMPLE);
    assign busy       = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start) state_nxt = ST_CLEAR;
                ST_CLEAR:  if (clr_last) state_nxt = (burn_in_q != 16'd0) ? ST_BURN : ST_SAMPLE;
                ST_BURN:   if (burn_evt && (burn_cnt == burn_in_q - 16'd1)) state_nxt = ST_SAMPLE;
                ST_SAMPLE: if (sample_fin) state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            clamp          <= '0;
            clamp_EN       <= 1'b0;
            burn_in_q      <= '0;
            num_samples_q  <= '0;
            clr_addr       <= '0;
            burn_cnt       <= '0;
            sample_cnt     <= '0;
            pc_out_q       <= '0;
            clk_delay_q    <= '0;
            clk_delay_prev <= '0;
            primed         <= 1'b0;
            s1_vld         <= 1'b0;
            s1_addr        <= '0;
            s1_cnt         <= '0;
            done           <= 1'b0;
            rd_valid       <= 1'b0;
            rd_data        <= '0;
        end else begin
            state          <= state_nxt;
            pc_out_q       <= pc_out;
            clk_delay_q    <= clk_delay;
            clk_delay_prev <= clk_delay_q;
            primed         <= !abort && ((state == ST_BURN) || (state == ST_SAMPLE));
            done           <= sample_fin && !abort;

            if (start_ok) begin
                clamp         <= cfg_clamp;
                clamp_EN      <= cfg_clamp_en;
                burn_in_q     <= cfg_burn_in;
                num_samples_q <= cfg_num_samples;
                burn_cnt      <= '0;
                sample_cnt    <= '0;
            end else begin
                if (burn_evt) burn_cnt <= burn_cnt + 16'd1;
                if (hist_evt) sample_cnt <= sample_cnt + 16'd1;
            end

            clr_addr <= (state == ST_CLEAR) ? clr_addr + NUM_PBITS'(1) : '0;

            // Bypass the bin being written this edge so back-to-back hits accumulate.
            s1_vld  <= hist_evt && !abort;
            s1_addr <= pc_out_q;
            s1_cnt  <= (s1_vld && (s1_addr == pc_out_q)) ? s1_inc : mem[pc_out_q];

            rd_valid <= rd_en && (state == ST_IDLE);
            rd_data  <= (rd_en && (state == ST_IDLE)) ? mem[rd_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_addr] <= '0;
        end else if (s1_vld) begin
            mem[s1_addr] <= s1_inc;
        end
    end

endmodule
